// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage.
//  - wb_state_t    : writeback FSM states
//  - exec_result_t : the record handed over by execute each cycle
//  - DEF_*         : default datapath widths used by the stage and its struct
package writeback_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_NREG   = 32;
    localparam int DEF_CNT_W  = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic                  wb_en;
        logic [REG_ADDR_W-1:0] rd;
        logic [DEF_XLEN-1:0]   rd_val;
        logic                  jump;
        logic [DEF_XLEN-1:0]   jump_pc;
        logic                  illegal;
    } exec_result_t;

endpackage

// File: rtl/writeback_regfile.sv
// Architectural register file: one write port, two combinational read ports.
//  clk, rst        : clock, asynchronous active-low clear of every register
//  we/waddr/wdata  : write port (writes to x0 are dropped)
//  raddr1/rdata1   : read port 1, write-first bypass
//  raddr2/rdata2   : read port 2, write-first bypass
module writeback_regfile
    import writeback_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [XLEN-1:0]         wdata,
    input  logic [$clog2(NREG)-1:0] raddr1,
    output logic [XLEN-1:0]         rdata1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    output logic [XLEN-1:0]         rdata2
);

    logic [XLEN-1:0] regs_q [NREG];

    // NOTE: the register array is cleared on reset because the core expects
    // every architectural register to read 0 after reset; a RAM macro would
    // need an explicit clearing sequence instead.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Write-first: a same-cycle write to the addressed register is forwarded
    // so decode sees the value that is about to be committed.
    always_comb begin
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs_q[raddr1];
        end
    end

    always_comb begin
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs_q[raddr2];
        end
    end

endmodule

// File: rtl/writeback.sv
// Final in-order pipeline stage.
//  clk, rst                  : clock, asynchronous active-low reset
//  result_valid/result_ready : handshake from execute (ready is always 1)
//  result                    : exec_result_t from execute
//  rs1_addr/rs1_data         : decode read port 1 (combinational, bypassed)
//  rs2_addr/rs2_data         : decode read port 2 (combinational, bypassed)
//  flush                     : squash fetch/decode/execute
//  redirect_valid/redirect_pc: fetch restart request (one cycle after a jump)
//  halted                    : sticky, an illegal instruction was committed
//  instret                   : committed-instruction counter
module writeback
    import writeback_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREG  = DEF_NREG,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  result_valid,
    output logic                  result_ready,
    input  exec_result_t          result,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [XLEN-1:0]       rs1_data,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  halted,
    output logic [CNT_W-1:0]      instret
);

    wb_state_t        state_q, state_d;
    logic             flush_q, flush_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic commit;
    logic rf_we;

    // Execute can never be stalled; results seen outside RUN are simply dropped.
    assign result_ready = 1'b1;
    assign commit       = result_valid && (state_q == RUN);
    // An illegal instruction must not leave architectural side effects.
    assign rf_we        = commit && result.wb_en && !result.illegal;

    writeback_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (result.rd),
        .wdata  (result.rd_val),
        .raddr1 (rs1_addr),
        .rdata1 (rs1_data),
        .raddr2 (rs2_addr),
        .rdata2 (rs2_data)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        halted_d         = halted_q;
        instret_d        = instret_q;

        if (commit && !result.illegal) begin
            instret_d = instret_q + CNT_W'(1);
        end

        unique case (state_q)
            RUN: begin
                // illegal wins over jump when both are flagged
                if (commit && result.illegal) begin
                    state_d  = TRAP;
                    flush_d  = 1'b1;
                    halted_d = 1'b1;
                end else if (commit && result.jump) begin
                    state_d          = FLUSH;
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = result.jump_pc;
                end
            end
            // One cycle of flush; anything arriving now is wrong-path.
            FLUSH: state_d = RUN;
            // Parked until reset, holding upstream squashed.
            TRAP: begin
                flush_d  = 1'b1;
                halted_d = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= RUN;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            halted_q         <= 1'b0;
            instret_q        <= '0;
        end else begin
            state_q          <= state_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            halted_q         <= halted_d;
            instret_q        <= instret_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign halted         = halted_q;
    assign instret        = instret_q;

endmodule
